// File: rtl/mem_stage.sv
// RV32I memory stage: EX/MEM register, data-memory access tracking, load alignment,
// and the MEM/WB register contents.
package rv32i_types;
  localparam logic [6:0] op_b_lui   = 7'b0110111;
  localparam logic [6:0] op_b_auipc = 7'b0010111;
  localparam logic [6:0] op_b_jal   = 7'b1101111;
  localparam logic [6:0] op_b_jalr  = 7'b1100111;
  localparam logic [6:0] op_b_br    = 7'b1100011;
  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;
  localparam logic [6:0] op_b_imm   = 7'b0010011;
  localparam logic [6:0] op_b_reg   = 7'b0110011;

  localparam logic [2:0] f3_slt  = 3'b010;
  localparam logic [2:0] f3_sltu = 3'b011;

  typedef struct packed {
    logic [2:0] funct3;
  } mem_ctrl_t;

  typedef struct packed {
    logic regf_we;
  } wb_ctrl_t;

  typedef struct packed {
    logic [31:0] inst_s;
    logic [63:0] order_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [4:0]  rd_s;
    logic [31:0] u_imm_s;
    logic [31:0] alu_out_s;
    logic        br_en_s;
    logic [31:0] mem_addr_s;
    logic [3:0]  dmem_rmask_s;
    logic [3:0]  dmem_wmask_s;
    logic [31:0] dmem_wdata_s;
    mem_ctrl_t   mem_ctrl_s;
    wb_ctrl_t    wb_ctrl_s;
    logic        valid_s;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic [31:0] inst_s;
    logic [63:0] order_s;
    logic [31:0] pc_s;
    logic [31:0] pc_next_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v_s;
    logic [31:0] rs2_v_s;
    logic [4:0]  rd_s;
    logic [31:0] rd_v_s;
    wb_ctrl_t    wb_ctrl_s;
    logic [31:0] dmem_addr_s;
    logic [3:0]  dmem_rmask_s;
    logic [3:0]  dmem_wmask_s;
    logic [31:0] dmem_wdata_s;
    logic [31:0] dmem_rdata_s;
    logic        valid_s;
  } mem_wb_stage_reg_t;
endpackage

// state | meaning
// IDLE  | no data-memory access outstanding
// WAIT  | request issued, response not yet seen
// HOLD  | response captured in rdata_q, instruction not yet retired
module mem_stage
  import rv32i_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              move,
  input  ex_mem_stage_reg_t ex_mem_next,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output logic              dmem_stall,
  output logic [31:0]       forward_mem_v,
  output mem_wb_stage_reg_t mem_wb_reg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  ex_mem_stage_reg_t r_q, r_d;
  logic [1:0]        state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;

  logic [31:0] raw;
  logic [31:0] shifted;
  logic [31:0] load_v;
  logic [31:0] rd_v;

  function automatic logic is_mem_op(input ex_mem_stage_reg_t e);
    return e.valid_s && ((e.dmem_rmask_s != 4'd0) || (e.dmem_wmask_s != 4'd0));
  endfunction

  // A move always re-targets the FSM at the newly latched entry.
  always_comb begin
    r_d     = r_q;
    state_d = state_q;
    rdata_d = rdata_q;
    if (move) begin
      r_d     = ex_mem_next;
      state_d = is_mem_op(ex_mem_next) ? WAIT : IDLE;
    end else if (state_q == WAIT && dmem_resp) begin
      state_d = HOLD;
      rdata_d = dmem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= '0;
      state_q <= IDLE;
      rdata_q <= 32'd0;
    end else begin
      r_q     <= r_d;
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    dmem_stall = (state_q == WAIT) && !dmem_resp;
    case (state_q)
      WAIT:    raw = dmem_rdata;
      HOLD:    raw = rdata_q;
      default: raw = 32'd0;
    endcase
  end

  always_comb begin
    shifted = raw >> {r_q.mem_addr_s[1:0], 3'b000};
    case (r_q.mem_ctrl_s.funct3)
      3'b000:  load_v = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_v = {24'd0, shifted[7:0]};
      3'b001:  load_v = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_v = {16'd0, shifted[15:0]};
      3'b010:  load_v = shifted;
      default: load_v = 32'd0;
    endcase
  end

  always_comb begin
    rd_v = r_q.alu_out_s;
    case (r_q.inst_s[6:0])
      op_b_lui:            rd_v = r_q.u_imm_s;
      op_b_jal, op_b_jalr: rd_v = r_q.pc_s + 32'd4;
      op_b_load:           rd_v = load_v;
      op_b_reg, op_b_imm: begin
        if (r_q.inst_s[14:12] == f3_slt || r_q.inst_s[14:12] == f3_sltu)
          rd_v = {31'd0, r_q.br_en_s};
      end
      default:             rd_v = r_q.alu_out_s;
    endcase
  end

  assign forward_mem_v = rd_v;

  always_comb begin
    mem_wb_reg              = '0;
    mem_wb_reg.inst_s       = r_q.inst_s;
    mem_wb_reg.order_s      = r_q.order_s;
    mem_wb_reg.pc_s         = r_q.pc_s;
    mem_wb_reg.pc_next_s    = r_q.pc_next_s;
    mem_wb_reg.rs1_s        = r_q.rs1_s;
    mem_wb_reg.rs2_s        = r_q.rs2_s;
    mem_wb_reg.rs1_v_s      = r_q.rs1_v_s;
    mem_wb_reg.rs2_v_s      = r_q.rs2_v_s;
    mem_wb_reg.rd_s         = r_q.rd_s;
    mem_wb_reg.rd_v_s       = rd_v;
    mem_wb_reg.wb_ctrl_s    = r_q.wb_ctrl_s;
    mem_wb_reg.dmem_addr_s  = r_q.mem_addr_s;
    mem_wb_reg.dmem_rmask_s = r_q.dmem_rmask_s;
    mem_wb_reg.dmem_wmask_s = r_q.dmem_wmask_s;
    mem_wb_reg.dmem_wdata_s = r_q.dmem_wdata_s;
    mem_wb_reg.dmem_rdata_s = raw;
    mem_wb_reg.valid_s      = move && r_q.valid_s && !dmem_stall;
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: constant vector table, hand-written multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_mem_stage;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              move = 1'b0;
  ex_mem_stage_reg_t ex_mem_next = '0;
  logic [31:0]       dmem_rdata = 32'd0;
  logic              dmem_resp = 1'b0;
  logic              dmem_stall;
  logic [31:0]       forward_mem_v;
  mem_wb_stage_reg_t mem_wb_reg;

  int n_vec = 0;
  int n_err = 0;

  mem_stage dut (
    .clk(clk), .rst(rst), .move(move), .ex_mem_next(ex_mem_next),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_stall(dmem_stall),
    .forward_mem_v(forward_mem_v), .mem_wb_reg(mem_wb_reg)
  );

  always #5 clk = ~clk;

  // Behavioural model: the latched entry, whether it still owes a response, and
  // whether that response has been collected.
  ex_mem_stage_reg_t m_r;
  logic              m_out, m_got;
  logic [31:0]       m_data;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_r <= '0; m_out <= 1'b0; m_got <= 1'b0; m_data <= 32'd0;
    end else if (move) begin
      m_r   <= ex_mem_next;
      m_out <= ex_mem_next.valid_s &&
               (ex_mem_next.dmem_rmask_s != 0 || ex_mem_next.dmem_wmask_s != 0);
      m_got <= 1'b0;
    end else if (m_out && !m_got && dmem_resp) begin
      m_got  <= 1'b1;
      m_data <= dmem_rdata;
    end
  end

  function automatic logic [31:0] m_rd(input ex_mem_stage_reg_t e, input logic [31:0] raw);
    logic [31:0] s;
    s = raw >> (8 * e.mem_addr_s[1:0]);
    case (e.inst_s[6:0])
      op_b_lui:            return e.u_imm_s;
      op_b_jal, op_b_jalr: return e.pc_s + 4;
      op_b_load:
        case (e.mem_ctrl_s.funct3)
          3'd0:    return 32'($signed(s[7:0]));
          3'd4:    return 32'(s[7:0]);
          3'd1:    return 32'($signed(s[15:0]));
          3'd5:    return 32'(s[15:0]);
          3'd2:    return s;
          default: return 0;
        endcase
      op_b_reg, op_b_imm:
        if (e.inst_s[14:12] == 3'd2 || e.inst_s[14:12] == 3'd3) return 32'(e.br_en_s);
        else return e.alu_out_s;
      default:             return e.alu_out_s;
    endcase
  endfunction

  function automatic ex_mem_stage_reg_t mk(input logic [6:0] opc, input logic [2:0] f3,
      input logic [31:0] addr, input logic [31:0] alu, input logic [31:0] uimm,
      input logic [31:0] pc, input logic br, input logic v);
    ex_mem_stage_reg_t e;
    e = '0;
    e.inst_s = {17'h0, f3, 5'd1, opc};
    e.rd_s = 5'd1;
    e.pc_s = pc;
    e.pc_next_s = pc + 4;
    e.mem_addr_s = addr;
    e.alu_out_s = alu;
    e.u_imm_s = uimm;
    e.br_en_s = br;
    e.valid_s = v;
    e.mem_ctrl_s.funct3 = f3;
    e.wb_ctrl_s.regf_we = 1'b1;
    e.dmem_rmask_s = (opc == op_b_load) ? 4'hF : 4'h0;
    e.dmem_wmask_s = (opc == op_b_store) ? 4'hF : 4'h0;
    e.dmem_wdata_s = 32'h5A5A_0000;
    e.order_s = 64'd7;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic mv, input logic rsp, input logic [31:0] rd,
                     input ex_mem_stage_reg_t nx);
    move = mv; dmem_resp = rsp; dmem_rdata = rd; ex_mem_next = nx;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [31:0] addr, rdata, alu, uimm, pc;
    logic        br;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];
  ex_mem_stage_reg_t nop;
  logic [6:0] opcs [9];

  initial begin
    tbl[0]  = '{"addi",   op_b_imm,   3'd0, 32'h0,   32'h0,         32'h10,   32'h0, 32'h0,   1'b0, 32'h0000_0010};
    tbl[1]  = '{"lb_103", op_b_load,  3'd0, 32'h103, 32'h8012_3456, 32'h0,    32'h0, 32'h0,   1'b0, 32'hFFFF_FF80};
    tbl[2]  = '{"lbu_103",op_b_load,  3'd4, 32'h103, 32'h8012_3456, 32'h0,    32'h0, 32'h0,   1'b0, 32'h0000_0080};
    tbl[3]  = '{"lh_102", op_b_load,  3'd1, 32'h102, 32'hBEEF_1234, 32'h0,    32'h0, 32'h0,   1'b0, 32'hFFFF_BEEF};
    tbl[4]  = '{"lhu_102",op_b_load,  3'd5, 32'h102, 32'hBEEF_1234, 32'h0,    32'h0, 32'h0,   1'b0, 32'h0000_BEEF};
    tbl[5]  = '{"lw_100", op_b_load,  3'd2, 32'h100, 32'hDEAD_BEEF, 32'h0,    32'h0, 32'h0,   1'b0, 32'hDEAD_BEEF};
    tbl[6]  = '{"lb_101", op_b_load,  3'd0, 32'h101, 32'h0000_7F00, 32'h0,    32'h0, 32'h0,   1'b0, 32'h0000_007F};
    tbl[7]  = '{"ld_f3_3",op_b_load,  3'd3, 32'h100, 32'hFFFF_FFFF, 32'h0,    32'h0, 32'h0,   1'b0, 32'h0};
    tbl[8]  = '{"lui",    op_b_lui,   3'd0, 32'h0,   32'h0,         32'h9,    32'h1234_5000, 32'h0, 1'b0, 32'h1234_5000};
    tbl[9]  = '{"jal",    op_b_jal,   3'd0, 32'h0,   32'h0,         32'h9,    32'h0, 32'h200, 1'b0, 32'h0000_0204};
    tbl[10] = '{"jalr",   op_b_jalr,  3'd0, 32'h0,   32'h0,         32'h9,    32'h0, 32'h300, 1'b0, 32'h0000_0304};
    tbl[11] = '{"slt",    op_b_reg,   3'd2, 32'h0,   32'h0,         32'hAAAA, 32'h0, 32'h0,   1'b1, 32'h0000_0001};
    tbl[12] = '{"sltiu",  op_b_imm,   3'd3, 32'h0,   32'h0,         32'h5,    32'h0, 32'h0,   1'b0, 32'h0};
    tbl[13] = '{"add",    op_b_reg,   3'd0, 32'h0,   32'h0,         32'h55,   32'h0, 32'h0,   1'b1, 32'h0000_0055};
    tbl[14] = '{"auipc",  op_b_auipc, 3'd0, 32'h0,   32'h0,         32'h1000, 32'h0, 32'h0,   1'b0, 32'h0000_1000};
    opcs = '{op_b_lui, op_b_auipc, op_b_jal, op_b_jalr, op_b_br,
             op_b_load, op_b_store, op_b_imm, op_b_reg};
    nop = mk(op_b_imm, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);

    // reset state
    @(negedge clk);
    chk("rst_stall", dmem_stall, 0);
    chk("rst_fwd", forward_mem_v, 0);
    chk("rst_valid", mem_wb_reg.valid_s, 0);
    chk("rst_rdata", mem_wb_reg.dmem_rdata_s, 0);
    adv();
    rst = 1'b1;

    // stray response after reset is dropped
    cyc(0, 1, 32'hFFFF_FFFF, nop);
    chk("stray_stall", dmem_stall, 0);
    chk("stray_rdata", mem_wb_reg.dmem_rdata_s, 0);
    adv();

    // table: latch entry, then retire it with a zero-wait response where relevant
    for (int i = 0; i < 15; i++) begin
      cyc(1, 0, 32'h0, mk(tbl[i].opc, tbl[i].f3, tbl[i].addr, tbl[i].alu, tbl[i].uimm,
                         tbl[i].pc, tbl[i].br, 1'b1));
      adv();
      cyc(1, tbl[i].opc == op_b_load, tbl[i].rdata, nop);
      chk({tbl[i].name, "_fwd"}, forward_mem_v, tbl[i].exp);
      chk({tbl[i].name, "_rdv"}, mem_wb_reg.rd_v_s, tbl[i].exp);
      chk({tbl[i].name, "_stall"}, dmem_stall, 0);
      chk({tbl[i].name, "_valid"}, mem_wb_reg.valid_s, 1);
      adv();
    end

    // lhu, response three cycles late
    cyc(1, 0, 0, mk(op_b_load, 3'd5, 32'h102, 0, 0, 32'h400, 0, 1));
    adv();
    cyc(0, 0, 32'h0, nop); chk("lhu_late_stall1", dmem_stall, 1); adv();
    cyc(0, 0, 32'h0, nop); chk("lhu_late_stall2", dmem_stall, 1); adv();
    cyc(1, 1, 32'hBEEF_1234, nop);
    chk("lhu_late_stall3", dmem_stall, 0);
    chk("lhu_late_rdv", mem_wb_reg.rd_v_s, 32'h0000_BEEF);
    chk("lhu_late_valid", mem_wb_reg.valid_s, 1);
    adv();
    cyc(0, 0, 32'h0, nop); chk("lhu_after_stall", dmem_stall, 0); adv();

    // lw, response while move is low, held until retire
    cyc(1, 0, 0, mk(op_b_load, 3'd2, 32'h200, 0, 0, 32'h500, 0, 1));
    adv();
    cyc(0, 1, 32'hDEAD_BEEF, nop);
    chk("hold_resp_stall", dmem_stall, 0);
    chk("hold_resp_fwd", forward_mem_v, 32'hDEAD_BEEF);
    chk("hold_resp_valid", mem_wb_reg.valid_s, 0);
    adv();
    for (int k = 0; k < 3; k++) begin
      cyc(0, 1, 32'h0, nop);
      chk("hold_fwd", forward_mem_v, 32'hDEAD_BEEF);
      chk("hold_stall", dmem_stall, 0);
      adv();
    end
    cyc(1, 0, 32'h0, nop);
    chk("hold_retire_rdv", mem_wb_reg.rd_v_s, 32'hDEAD_BEEF);
    chk("hold_retire_raw", mem_wb_reg.dmem_rdata_s, 32'hDEAD_BEEF);
    chk("hold_retire_valid", mem_wb_reg.valid_s, 1);
    adv();

    // sw then lw back-to-back, each one cycle late
    cyc(1, 0, 0, mk(op_b_store, 3'd2, 32'h100, 32'h100, 0, 32'h600, 0, 1));
    adv();
    cyc(0, 0, 32'h0, nop); chk("sw_stall", dmem_stall, 1); adv();
    cyc(1, 1, 32'h0, mk(op_b_load, 3'd2, 32'h104, 0, 0, 32'h604, 0, 1));
    chk("sw_done_stall", dmem_stall, 0);
    chk("sw_done_valid", mem_wb_reg.valid_s, 1);
    adv();
    cyc(0, 0, 32'h0, nop); chk("lw_b2b_stall", dmem_stall, 1); adv();
    cyc(1, 1, 32'h1122_3344, nop);
    chk("lw_b2b_stall2", dmem_stall, 0);
    chk("lw_b2b_fwd", forward_mem_v, 32'h1122_3344);
    chk("lw_b2b_valid", mem_wb_reg.valid_s, 1);
    adv();
    cyc(0, 1, 32'h0, nop); chk("idle_resp_stall", dmem_stall, 0); adv();

    // reset while waiting, then a stray response
    cyc(1, 0, 0, mk(op_b_load, 3'd2, 32'h300, 0, 0, 32'h700, 0, 1));
    adv();
    cyc(0, 0, 32'h0, nop);
    chk("rstw_pre_stall", dmem_stall, 1);
    #1 rst = 1'b0;
    #1;
    chk("rstw_stall", dmem_stall, 0);
    chk("rstw_fwd", forward_mem_v, 0);
    chk("rstw_rdv", mem_wb_reg.rd_v_s, 0);
    chk("rstw_valid", mem_wb_reg.valid_s, 0);
    adv();
    rst = 1'b1;
    cyc(0, 1, 32'hFFFF_FFFF, nop);
    chk("rstw_stray_stall", dmem_stall, 0);
    chk("rstw_stray_fwd", forward_mem_v, 0);
    chk("rstw_stray_raw", mem_wb_reg.dmem_rdata_s, 0);
    chk("rstw_stray_valid", mem_wb_reg.valid_s, 0);
    adv();

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      logic rsp, mv, st, do_rst;
      logic [31:0] rd, raw_e;
      ex_mem_stage_reg_t e;
      do_rst = ($urandom_range(0, 63) == 0);
      rst = !do_rst;
      rsp = ($urandom_range(0, 2) == 0);
      rd = $urandom;
      st = !do_rst && m_out && !m_got && !rsp;
      mv = st ? 1'b0 : 1'($urandom_range(0, 1));
      e = mk(opcs[$urandom_range(0, 8)], 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      cyc(mv, rsp, rd, e);
      st = m_out && !m_got && !dmem_resp;
      raw_e = m_got ? m_data : (m_out ? dmem_rdata : 32'd0);
      chk("rnd_stall", dmem_stall, st);
      chk("rnd_fwd", forward_mem_v, m_rd(m_r, raw_e));
      chk("rnd_raw", mem_wb_reg.dmem_rdata_s, raw_e);
      chk("rnd_valid", mem_wb_reg.valid_s, move && m_r.valid_s && !st);
      chk("rnd_pc", mem_wb_reg.pc_s, m_r.pc_s);
      adv();
      rst = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage RV32I pipeline, directly downstream of the execute stage. Owns the EX/MEM pipeline register and tracks the data-memory access that execute issued. Stalls the pipeline until the data-memory response arrives, then aligns and extends load data. Drives the memory-to-execute forwarding value and the MEM/WB register contents.

## Interface
- No parameters; widths are fixed by `rv32i_types`.
- `clk`  in  1  pipeline clock.
- `rst`  in  1  reset: asynchronous, active-low.
- `move`  in  1  global pipeline advance; EX/MEM and MEM/WB latch on edges where it is 1.
- `ex_mem_next`  in  `ex_mem_stage_reg_t`  execute-stage output struct.
- `dmem_rdata`  in  32  data-memory read data; valid only while `dmem_resp`=1.
- `dmem_resp`  in  1  data-memory response for the outstanding request.
- `dmem_stall`  out  1  the access is outstanding and the response has not arrived; the pipeline must hold `move`=0.
- `forward_mem_v`  out  32  rd value of the instruction in MEM, used for forwarding.
- `mem_wb_reg`  out  `mem_wb_stage_reg_t`  contents for the MEM/WB register.

## Operation
- EX/MEM register `r`:
  - On reset, every field of `r` is 0.
  - On an edge with `move`=1, `r` <= `ex_mem_next`; otherwise `r` holds.
- An entry is a memory op when `r.valid_s`=1 and (`r.dmem_rmask_s`!=0 or `r.dmem_wmask_s`!=0).
- States:
  - IDLE: no access outstanding.
  - WAIT: request issued, response not yet seen.
  - HOLD: response captured, instruction not yet retired.
- Transitions:
  - Any edge with `move`=1 enters WAIT if the newly latched entry is a memory op; otherwise it enters IDLE. This overrides every other transition.
  - WAIT, `dmem_resp`=1, `move`=0: go to HOLD and capture `dmem_rdata` into `rdata_q`.
  - HOLD, `move`=0: stay in HOLD; ignore `dmem_resp`.
  - IDLE: ignore `dmem_resp`. A stray response after reset is dropped.
- `dmem_stall` = (state==WAIT) and not `dmem_resp`.
- Raw data:
  - In WAIT, raw data is `dmem_rdata` (combinational pass-through on the response cycle).
  - In HOLD, raw data is `rdata_q`.
- Load alignment: shift raw data right by 8·`r.mem_addr_s[1:0]`, then apply `r.mem_ctrl_s.funct3`:
  - lb 000 sign-extends bits [7:0]; lbu 100 zero-extends bits [7:0].
  - lh 001 sign-extends bits [15:0]; lhu 101 zero-extends bits [15:0].
  - lw 010 uses all 32 bits.
  - Any other funct3 gives 0.
- rd value, selected by `r.inst_s[6:0]`:
  - op_b_lui: `u_imm_s`.
  - op_b_jal or op_b_jalr: `pc_s`+4.
  - op_b_load: the aligned load data.
  - op_b_reg or op_b_imm with funct3 slt or sltu: {31'b0, `br_en_s`}.
  - All other opcodes: `alu_out_s`.
- `forward_mem_v` = the rd value. For loads it is meaningful only when `dmem_stall`=0. The load-use bubble is owned by the hazard unit.
- `mem_wb_reg`:
  - Passes inst, order, pc, pc_next, rs1/rs2 indices and values, rd index, wb_ctrl, dmem addr/masks/wdata unchanged from `r`.
  - `rd_v_s` = the rd value; `dmem_rdata_s` = raw data.
  - `valid_s` = `move` & `r.valid_s` & !`dmem_stall`.

## Timing
- Reset values:
  - state IDLE, `r` all zero, `rdata_q` 0.
  - `dmem_stall`=0, `forward_mem_v`=0.
  - `mem_wb_reg.valid_s`=0.
- Reset is asserted asynchronously and released on a clock edge.
- Reset mid-access: the access is abandoned and state returns to IDLE.
- Request/response ordering:
  - Execute raises `dmem_req` in cycle T. The entry is in `r` from T+1.
  - A zero-wait response at T+1 gives `dmem_stall`=0 at T+1, so the stage adds no stall cycle.
  - A response at T+k gives `dmem_stall`=1 for cycles T+1..T+k-1.
- Stores also wait for `dmem_resp`; their data is ignored.
- Response arrives while `move`=0 for another reason (e.g. instruction-memory stall): go to HOLD, hold the data, retire on the first edge with `move`=1.
- Response and `move`=1 in the same cycle: the data goes straight to MEM/WB. The stage passes through neither HOLD nor IDLE; the next state follows the new entry.

## Test plan
- ALU op: `addi` with `alu_out_s`=0x0000_0010, `move`=1 -> `forward_mem_v`=0x10, `dmem_stall`=0, state IDLE.
- lb from address 0x103 with `dmem_resp` at T+1 and `dmem_rdata`=0x80xx_xxxx -> `rd_v_s`=0xFFFF_FF80, no stall.
- lhu from address 0x102 with the response 3 cycles late and `dmem_rdata`=0xBEEF_1234 -> `dmem_stall`=1 for 2 cycles, then `rd_v_s`=0x0000_BEEF.
- lw with response while `move`=0 for 4 cycles, `dmem_rdata`=0xDEAD_BEEF then 0 -> HOLD, `rd_v_s`=0xDEAD_BEEF at retire.
- sw followed by lw back-to-back, each with a 1-cycle-late response -> two separate stall cycles, WAIT re-entered directly.
- Assert `rst` low while in WAIT, then send a stray `dmem_resp` after release -> state IDLE, all outputs 0, `mem_wb_reg.valid_s`=0.
